// File: rtl/bus_arb_mux_if.sv
// Bus arbitration mux signal bundle: source-side request/data and registered bus results.
interface bus_arb_mux_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SRC  = 25,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned CNT_W  = 16
);

  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_out;
  logic                    hold;
  logic                    err_clr;
  logic [DATA_W-1:0]       bus_out;
  logic                    bus_valid;
  logic [SEL_W-1:0]        bus_sel;
  logic                    conflict;
  logic                    err_sticky;
  logic [CNT_W-1:0]        xfer_count;

  // Side that drives sources and observes the bus
  modport master (
    output src_data, src_out, hold, err_clr,
    input  bus_out, bus_valid, bus_sel, conflict, err_sticky, xfer_count
  );

  // The arbiter itself
  modport slave (
    input  src_data, src_out, hold, err_clr,
    output bus_out, bus_valid, bus_sel, conflict, err_sticky, xfer_count
  );

endinterface

// File: rtl/bus_arb_mux.sv
// Samples per-source drive enables each cycle, resolves single/multiple drivers,
// and registers the selected word onto a shared bus with conflict reporting.
module bus_arb_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SRC  = 25,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned STRICT = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          clr,
  bus_arb_mux_if.slave  bif
);

  // Wide enough to hold a count of every source being enabled at once
  localparam int unsigned PC_W = $clog2(N_SRC + 1);

  logic [DATA_W-1:0] r_bus_out;
  logic              r_bus_valid;
  logic [SEL_W-1:0]  r_bus_sel;
  logic              r_conflict;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_xfer_count;

  logic [PC_W-1:0]   w_pop;
  logic [SEL_W-1:0]  w_low;
  logic [DATA_W-1:0] w_word;
  logic              w_one;
  logic              w_multi;
  logic              w_load;

  logic [DATA_W-1:0] w_bus_out_nxt;
  logic              w_bus_valid_nxt;
  logic [SEL_W-1:0]  w_bus_sel_nxt;
  logic              w_conflict_nxt;
  logic              w_err_sticky_nxt;
  logic [CNT_W-1:0]  w_xfer_count_nxt;

  // Population count of enables and index of the lowest enabled source
  always_comb begin
    w_pop = '0;
    w_low = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      w_pop = w_pop + PC_W'(bif.src_out[i]);
      if (bif.src_out[i]) begin
        w_low = SEL_W'(i);
      end
    end
  end

  // Word mux driven by the resolved index
  always_comb begin
    w_word = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (SEL_W'(i) == w_low) begin
        w_word = bif.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for all bus registers; a same-cycle conflict overrides err_clr
  always_comb begin
    w_one            = (w_pop == PC_W'(1));
    w_multi          = (w_pop >= PC_W'(2));
    w_load           = 1'b0;
    w_bus_out_nxt    = r_bus_out;
    w_bus_sel_nxt    = r_bus_sel;
    w_bus_valid_nxt  = 1'b0;
    w_conflict_nxt   = 1'b0;
    w_err_sticky_nxt = bif.err_clr ? 1'b0 : r_err_sticky;
    w_xfer_count_nxt = r_xfer_count;
    if (!bif.hold) begin
      if (w_multi) begin
        w_conflict_nxt   = 1'b1;
        w_err_sticky_nxt = 1'b1;
      end
      w_load = w_one || (w_multi && (STRICT == 0));
      if (w_load) begin
        w_bus_out_nxt    = w_word;
        w_bus_sel_nxt    = w_low;
        w_bus_valid_nxt  = 1'b1;
        w_xfer_count_nxt = r_xfer_count + CNT_W'(1);
      end
    end
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bus_out    <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_sel    <= '0;
      r_conflict   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_bus_out    <= w_bus_out_nxt;
      r_bus_valid  <= w_bus_valid_nxt;
      r_bus_sel    <= w_bus_sel_nxt;
      r_conflict   <= w_conflict_nxt;
      r_err_sticky <= w_err_sticky_nxt;
      r_xfer_count <= w_xfer_count_nxt;
    end
  end

  assign bif.bus_out    = r_bus_out;
  assign bif.bus_valid  = r_bus_valid;
  assign bif.bus_sel    = r_bus_sel;
  assign bif.conflict   = r_conflict;
  assign bif.err_sticky = r_err_sticky;
  assign bif.xfer_count = r_xfer_count;

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus word width in bits.
REQ-002 SHALL have parameter N_SRC, default 25, number of bus sources (2..64).
REQ-003 SHALL have parameter SEL_W, default 5, index width; SEL_W SHALL equal ceil(log2(N_SRC)).
REQ-004 SHALL have parameter STRICT, default 0; 0 = priority resolve on conflict, 1 = reject on conflict.
REQ-005 SHALL have parameter CNT_W, default 16, transfer counter width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input, clr input.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 clr  input  1  asynchronous active-low reset.
REQ-009 src_data  input  N_SRC*DATA_W  flattened source words; source i at bits [i*DATA_W +: DATA_W].
REQ-010 src_out  input  N_SRC  per-source drive enables; bit i requests source i onto the bus.
REQ-011 hold  input  1  freeze request; suppresses sampling that cycle.
REQ-012 err_clr  input  1  clears err_sticky.
REQ-013 bus_out  output  DATA_W  registered bus word.
REQ-014 bus_valid  output  1  bus_out was loaded on the last edge.
REQ-015 bus_sel  output  SEL_W  index of the source currently held in bus_out.
REQ-016 conflict  output  1  one-cycle pulse: multiple enables were sampled.
REQ-017 err_sticky  output  1  latched conflict indicator.
REQ-018 xfer_count  output  CNT_W  count of accepted transfers.

Function
REQ-019 All outputs SHALL be registered; a source sampled at edge k SHALL appear on bus_out after edge k (latency 1 cycle).
REQ-020 hold=0 and zero bits of src_out set: bus_out and bus_sel hold, bus_valid<=0, xfer_count holds, conflict<=0.
REQ-021 hold=0 and exactly one bit i set: bus_out<=source i, bus_sel<=i, bus_valid<=1, xfer_count increments, conflict<=0.
REQ-022 hold=0 and two or more bits set: conflict<=1 for one cycle and err_sticky<=1.
REQ-023 On a conflict with STRICT=0, the lowest set index SHALL win and be treated exactly as REQ-021.
REQ-024 On a conflict with STRICT=1, bus_out and bus_sel SHALL hold, bus_valid<=0, xfer_count SHALL hold.
REQ-025 hold=1: bus_out, bus_sel and xfer_count hold, bus_valid<=0, conflict<=0; src_out is ignored and no conflict is detected.
REQ-026 err_clr=1 SHALL clear err_sticky on the next edge; a conflict detected in the same cycle SHALL win, leaving err_sticky=1.
REQ-027 xfer_count SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-028 Enable bits at index >= N_SRC SHALL not exist; src_out is exactly N_SRC wide, so no out-of-range select is possible.
REQ-029 Conflict detection SHALL be a true population count of at least 2, not a parity or one-hot check.

Reset
REQ-030 clr=0 SHALL immediately force bus_out=0, bus_valid=0, bus_sel=0, conflict=0, err_sticky=0, xfer_count=0, regardless of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the sampled source; the first post-reset transfer SHALL be governed solely by src_out at the first edge after clr=1.
REQ-032 Deassertion of clr SHALL take effect on its own; no edge is sampled while clr=0.

Verification
REQ-033 Reset: clr=0 with random inputs toggling -> all outputs 0 throughout; release, src_out=0 -> outputs remain 0.
REQ-034 Single source: src_out=1<<20, source 20=0xDEADBEEF -> next cycle bus_out=0xDEADBEEF, bus_sel=20, bus_valid=1, xfer_count=1; then src_out=0 -> bus_out holds, bus_valid=0.
REQ-035 Conflict, STRICT=0: src_out bits 3 and 7, source 3=0x3, source 7=0x7 -> bus_out=0x3, bus_sel=3, conflict pulse 1 cycle, err_sticky=1, count increments.
REQ-036 Conflict, STRICT=1: same stimulus -> bus_out unchanged, bus_valid=0, count unchanged, conflict=1, err_sticky=1; err_clr together with a new conflict -> err_sticky stays 1; err_clr alone -> 0.
REQ-037 Hold: hold=1 with src_out=1<<5 for 3 cycles -> no change to bus_out/bus_sel/xfer_count, bus_valid=0; hold=0 -> source 5 loads next cycle.
REQ-038 Wrap: CNT_W=4, 17 single-source transfers -> xfer_count goes 15 then 0 then 1.
